// File: rtl/routine_pkg.sv
// Shared definitions for the routine output arbiter: bus field layout,
// the blanked-board pattern and the arbiter state encoding.
package routine_pkg;

    localparam int BUS_W   = 46;
    localparam int RED_LSB = 36;
    localparam int GRN_LSB = 28;
    localparam int SSD_LSB = 0;

    // LEDs off (active-high) and every 7-seg segment off (active-low).
    localparam logic [BUS_W-1:0] BLANK_PATTERN = {
        {(BUS_W - RED_LSB){1'b0}},
        {(RED_LSB - GRN_LSB){1'b0}},
        {(GRN_LSB - SSD_LSB){1'b1}}
    };

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BLANK = 2'd1,
        ST_START = 2'd2
    } arb_state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/select_debouncer.sv
// Two-flop synchronizer plus stability debouncer for the board routine
// select switch; AcceptStrobe pulses for one cycle when Accepted changes.
module select_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] SelectIn,
    output logic [1:0] Accepted,
    output logic       AcceptStrobe
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       cand_q, cand_d;
    logic [1:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             strobe_q, strobe_d;

    // cnt_q holds how many consecutive cycles sync2_q has equalled cand_q.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        strobe_d = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q == CNT_LAST) begin
            if (cand_q != acc_q) begin
                acc_d    = cand_q;
                strobe_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q  <= 2'd0;
            sync2_q  <= 2'd0;
            cand_q   <= 2'd0;
            cnt_q    <= '0;
            acc_q    <= 2'd0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= SelectIn;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            strobe_q <= strobe_d;
        end
    end

    assign Accepted     = acc_q;
    assign AcceptStrobe = strobe_q;

endmodule

// File: rtl/routine_output_arbiter.sv
// Hands the board bus to one of four routines, blanking the board between
// owners. Optional Freeze input is enabled by defining ARBITER_FREEZE_EN.
module routine_output_arbiter
    import routine_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLANK_CYCLES    = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [1:0]       SelectIn,
    input  logic [BUS_W-1:0] Bus0,
    input  logic [BUS_W-1:0] Bus1,
    input  logic [BUS_W-1:0] Bus2,
    input  logic [BUS_W-1:0] Bus3,
`ifdef ARBITER_FREEZE_EN
    input  logic             Freeze,
`endif
    output logic [3:0]       RoutineRun,
    output logic [BUS_W-1:0] OutputBus,
    output logic [1:0]       ActiveSel,
    output logic             Switching,
    output arb_state_t       DbgState
);

    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    logic [1:0]       accepted;
    logic             accept_strobe;
    logic             frozen;
    logic [BUS_W-1:0] sel_bus;

    arb_state_t       state_q, state_d;
    logic [BW-1:0]    blank_cnt_q, blank_cnt_d;
    logic [1:0]       active_q, active_d;
    logic [1:0]       pending_q, pending_d;
    logic [BUS_W-1:0] out_q, out_d;

    select_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .Clock       (Clock),
        .Reset       (Reset),
        .SelectIn    (SelectIn),
        .Accepted    (accepted),
        .AcceptStrobe(accept_strobe)
    );

`ifdef ARBITER_FREEZE_EN
    assign frozen = Freeze;
`else
    assign frozen = 1'b0;
`endif

    always_comb begin
        case (active_q)
            2'd0:    sel_bus = Bus0;
            2'd1:    sel_bus = Bus1;
            2'd2:    sel_bus = Bus2;
            default: sel_bus = Bus3;
        endcase
    end

    // The output register only captures a routine bus while staying in RUN,
    // so the first BLANK cycle and the first RUN cycle both show the blank.
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        active_d    = active_q;
        pending_d   = pending_q;
        out_d       = BLANK_PATTERN;
        case (state_q)
            ST_RUN: begin
                if (frozen) begin
                    out_d = out_q;
                end else if (accepted != active_q) begin
                    state_d     = ST_BLANK;
                    pending_d   = accepted;
                    blank_cnt_d = '0;
                end else begin
                    out_d = sel_bus;
                end
            end
            ST_BLANK: begin
                if (accept_strobe) begin
                    pending_d   = accepted;
                    blank_cnt_d = '0;
                end else if (blank_cnt_q == BLANK_LAST) begin
                    state_d  = ST_START;
                    active_d = pending_q;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            ST_START: state_d = ST_RUN;
            default:  state_d = ST_BLANK;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_BLANK;
            blank_cnt_q <= '0;
            active_q    <= 2'd0;
            pending_q   <= 2'd0;
            out_q       <= BLANK_PATTERN;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
        end
    end

    assign RoutineRun = (state_q == ST_BLANK) ? 4'b0000 : onehot4(active_q);
    assign OutputBus  = out_q;
    assign ActiveSel  = active_q;
    assign Switching  = (state_q != ST_RUN);
    assign DbgState   = state_q;

endmodule

// File: doc/routine_output_arbiter.md
ROUTINE_OUTPUT_ARBITER -- requirements
Module: routine_output_arbiter

Interface
REQ-001 Parameters SHALL be: DEBOUNCE_CYCLES, 16, consecutive stable cycles before a select change is accepted.
REQ-002 BLANK_CYCLES, 4: cycles the board is blanked between routines, min 1.
REQ-003 Clock  in  1  single clock; all state on posedge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 SelectIn  in  2  raw board switch routine select; asynchronous to Clock.
REQ-006 Bus0..Bus3  in  46 each  routine output buses: [45:36] red LEDs, [35:28] green LEDs, [27:0] four 7-seg digits, active-low segments.
REQ-007 RoutineRun  out  4  per-routine run enable; 0 holds that routine in its cleared state.
REQ-008 OutputBus  out  46  registered board bus, same field layout as Bus0..Bus3.
REQ-009 ActiveSel  out  2  index of the routine currently owning the board.
REQ-010 Switching  out  1  high in BLANK and START states.

Function
REQ-011 SelectIn SHALL pass a 2-flop synchronizer before any use.
REQ-012 The debouncer SHALL accept a synchronized value only after it is unchanged for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-013 FSM states SHALL be RUN, BLANK and START.
REQ-014 RUN: OutputBus <= Bus[ActiveSel] each cycle (1-cycle latency); RoutineRun = onehot(ActiveSel).
REQ-015 RUN -> BLANK when the accepted select differs from ActiveSel; the value is latched as Pending.
REQ-016 Accepting a select equal to ActiveSel in RUN SHALL cause no action.
REQ-017 BLANK: RoutineRun = 4'b0000; OutputBus = BLANK_PATTERN (bits 45:28 = 0, bits 27:0 = 1); counts BLANK_CYCLES.
REQ-018 A new accepted select during BLANK SHALL overwrite Pending and restart the blank count.
REQ-019 At the end of BLANK, ActiveSel <= Pending and the FSM SHALL enter START, including when Pending equals the old ActiveSel.
REQ-020 START (exactly 1 cycle): RoutineRun = onehot(ActiveSel); OutputBus = BLANK_PATTERN; then the FSM SHALL enter RUN.
REQ-021 The first RUN cycle SHALL therefore present the routine's first post-enable output.
REQ-022 At most one RoutineRun bit SHALL ever be high.

Reset
REQ-023 Reset low SHALL immediately force: state BLANK, blank count 0, ActiveSel 0, Pending 0, RoutineRun 0, OutputBus BLANK_PATTERN, Switching 1, debouncer count 0 and accepted value 0.
REQ-024 After reset release, the block SHALL run BLANK_CYCLES of BLANK, then 1 START cycle, then RUN on routine 0.
REQ-025 Reset asserted mid-switch SHALL discard Pending.

Configuration
REQ-026 With ARBITER_FREEZE_EN defined, an input Freeze (1 bit) SHALL be added.
REQ-027 Freeze high in RUN: OutputBus holds its value, RoutineRun is unchanged, and RUN -> BLANK is deferred until Freeze is low; the debouncer keeps running.
REQ-028 Freeze SHALL be ignored in BLANK and START.
REQ-029 Without ARBITER_FREEZE_EN, the Freeze port and its logic SHALL be absent.

Structure
REQ-030 Shared package routine_pkg SHALL hold: BUS_W=46; field offsets RED_LSB=36, GRN_LSB=28, SSD_LSB=0; BLANK_PATTERN; arbiter state enum.
REQ-031 The synchronizer plus debouncer SHALL be a sub-module select_debouncer (parameter DEBOUNCE_CYCLES; out Accepted[1:0], AcceptStrobe).

Verification
REQ-032 Reset pulse, SelectIn=0, Bus0=46'h1: OutputBus = BLANK_PATTERN for 4+1 cycles after release, RoutineRun=0001 from START, OutputBus=46'h1 from the first RUN cycle +1.
REQ-033 SelectIn 0->2 held 20 cycles: accepted 16 cycles after synchronization; RoutineRun 0000 for 4 cycles, then 0100; ActiveSel=2; OutputBus tracks Bus2.
REQ-034 SelectIn toggles 0->1->0 with 5-cycle glitches: no acceptance, no BLANK entry, ActiveSel stays 0.
REQ-035 Select 1 accepted, then 3 accepted during BLANK: blank count restarts; final ActiveSel=3; RoutineRun bit 1 never asserted.
REQ-036 Reset low on the 2nd BLANK cycle of a 0->2 switch: immediate BLANK_PATTERN and RoutineRun=0; after release, ActiveSel=0.
REQ-037 With ARBITER_FREEZE_EN: Freeze=1 in RUN, Bus0 changed to 46'h2A: OutputBus holds; select 1 accepted; no switch until Freeze=0, then the normal BLANK/START sequence.
